// File: rtl/inst_fetch_queue.sv
// Fetch PC generator, JAL/branch pre-decoder and circular instruction queue
// between the icache/branch predictor and the issue stage.
module inst_fetch_queue #(
  parameter int          IFQ_WIDTH  = 4,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter bit          JALR_STALL = 1'b1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clr_in,
  input  logic [31:0]          clr_pc_in,
  output logic                 ifq_to_ic_valid,
  output logic [31:0]          ifq_to_ic_pc,
  input  logic                 ic_to_ifq_ready,
  input  logic [31:0]          ic_to_ifq_inst,
  output logic [31:0]          ifq_to_bp_pc,
  input  logic                 bp_to_ifq_prediction,
  output logic                 out_valid,
  output logic [31:0]          out_inst,
  output logic [31:0]          out_pc,
  output logic                 out_prediction,
  output logic [31:0]          out_pc_next,
  input  logic                 iu_ready_in,
  output logic [IFQ_WIDTH:0]   ifq_count
);

  localparam int                   DEPTH    = 1 << IFQ_WIDTH;
  localparam logic [IFQ_WIDTH:0]   FULL_CNT = (IFQ_WIDTH+1)'(DEPTH);
  localparam logic [IFQ_WIDTH:0]   CNT_ONE  = (IFQ_WIDTH+1)'(1);
  localparam logic [IFQ_WIDTH-1:0] PTR_ONE  = IFQ_WIDTH'(1);
  localparam logic [6:0]           OP_JAL    = 7'b1101111;
  localparam logic [6:0]           OP_BRANCH = 7'b1100011;
  localparam logic [6:0]           OP_JALR   = 7'b1100111;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [IFQ_WIDTH-1:0] head_q, head_d;
  logic [IFQ_WIDTH-1:0] tail_q, tail_d;
  logic [IFQ_WIDTH:0]   count_q, count_d;

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];
  logic        pred_mem [DEPTH];
  logic [31:0] next_mem [DEPTH];

  logic        push, pop;
  logic        jalr_hit, pred_taken;
  logic [31:0] imm_j, imm_b, pred_next;

  assign ifq_to_ic_valid = (state_q == RUN) && (count_q != FULL_CNT) && rst_in && !clr_in;
  assign ifq_to_ic_pc    = pc_q;
  assign ifq_to_bp_pc    = pc_q;
  assign push            = ifq_to_ic_valid && ic_to_ifq_ready && rdy_in;
  assign out_valid       = (count_q != '0);
  assign pop             = out_valid && iu_ready_in && rdy_in && !clr_in;
  assign ifq_count       = count_q;

  assign out_inst       = inst_mem[head_q];
  assign out_pc         = pc_mem[head_q];
  assign out_prediction = pred_mem[head_q];
  assign out_pc_next    = next_mem[head_q];

  assign imm_j = {{12{ic_to_ifq_inst[31]}}, ic_to_ifq_inst[19:12], ic_to_ifq_inst[20],
                  ic_to_ifq_inst[30:21], 1'b0};
  assign imm_b = {{20{ic_to_ifq_inst[31]}}, ic_to_ifq_inst[7], ic_to_ifq_inst[30:25],
                  ic_to_ifq_inst[11:8], 1'b0};

  // Pre-decode of the word returned for the current pc.
  always_comb begin
    pred_taken = 1'b0;
    pred_next  = pc_q + 32'd4;
    jalr_hit   = 1'b0;
    case (ic_to_ifq_inst[6:0])
      OP_JAL: begin
        pred_taken = 1'b1;
        pred_next  = pc_q + imm_j;
      end
      OP_BRANCH: begin
        pred_taken = bp_to_ifq_prediction;
        if (bp_to_ifq_prediction) pred_next = pc_q + imm_b;
      end
      OP_JALR: jalr_hit = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in) begin
      if (clr_in) begin
        state_d = RUN;
        pc_d    = clr_pc_in;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push) begin
          tail_d = tail_q + PTR_ONE;
          pc_d   = pred_next;
          if (JALR_STALL && jalr_hit) state_d = HALT;
        end
        if (pop) head_d = head_q + PTR_ONE;
        case ({push, pop})
          2'b10:   count_d = count_q + CNT_ONE;
          2'b01:   count_d = count_q - CNT_ONE;
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset; count gates every read.
  always_ff @(posedge clk_in) begin
    if (push) begin
      inst_mem[tail_q] <= ic_to_ifq_inst;
      pc_mem[tail_q]   <= pc_q;
      pred_mem[tail_q] <= pred_taken;
      next_mem[tail_q] <= pred_next;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed and randomized checks of inst_fetch_queue against a queue-based
// behavioural model; a second instance covers the non-stalling JALR option.
module tb_inst_fetch_queue;

  localparam int W     = 2;
  localparam int DEPTH = 1 << W;
  localparam logic [31:0] ADDI  = 32'h00100093;
  localparam logic [31:0] JAL20 = 32'h0200006F;  // jal x0, +0x20
  localparam logic [31:0] BRM8  = 32'hFE000CE3;  // beq x0, x0, -8
  localparam logic [31:0] JALR  = 32'h00008067;  // jalr x0, 0(x1)

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in, ic_ready, bp_pred, iu_ready;
  logic [31:0] clr_pc, ic_inst;
  logic        ic_valid, o_valid, o_pred;
  logic [31:0] ic_pc, bp_pc, o_inst, o_pc, o_next;
  logic [W:0]  count;

  logic        b_ic_ready;
  logic [31:0] b_inst;
  logic        b_ic_valid, b_o_valid, b_o_pred;
  logic [31:0] b_ic_pc, b_bp_pc, b_o_inst, b_o_pc, b_o_next;
  logic [4:0]  b_count;

  always #5 clk_in = ~clk_in;

  inst_fetch_queue #(.IFQ_WIDTH(W), .RESET_PC(32'h0), .JALR_STALL(1'b1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in), .clr_pc_in(clr_pc),
    .ifq_to_ic_valid(ic_valid), .ifq_to_ic_pc(ic_pc), .ic_to_ifq_ready(ic_ready),
    .ic_to_ifq_inst(ic_inst), .ifq_to_bp_pc(bp_pc), .bp_to_ifq_prediction(bp_pred),
    .out_valid(o_valid), .out_inst(o_inst), .out_pc(o_pc), .out_prediction(o_pred),
    .out_pc_next(o_next), .iu_ready_in(iu_ready), .ifq_count(count));

  inst_fetch_queue #(.IFQ_WIDTH(4), .RESET_PC(32'h40), .JALR_STALL(1'b0)) bdut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(1'b1), .clr_in(1'b0), .clr_pc_in(32'h0),
    .ifq_to_ic_valid(b_ic_valid), .ifq_to_ic_pc(b_ic_pc), .ic_to_ifq_ready(b_ic_ready),
    .ic_to_ifq_inst(b_inst), .ifq_to_bp_pc(b_bp_pc), .bp_to_ifq_prediction(1'b0),
    .out_valid(b_o_valid), .out_inst(b_o_inst), .out_pc(b_o_pc), .out_prediction(b_o_pred),
    .out_pc_next(b_o_next), .iu_ready_in(1'b0), .ifq_count(b_count));

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] nxt;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_pc = 32'h0;
  bit          m_halt = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected entry built from the instruction's meaning, offsets summed as integers.
  function automatic entry_t predict(input logic [31:0] i, input logic [31:0] pc, input logic bp);
    entry_t e;
    int off;
    e.inst = i; e.pc = pc; e.pred = 1'b0; e.nxt = pc + 32'd4;
    if (i[6:0] == 7'h6F) begin
      off = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
            + int'(i[30:21]) * 2;
      e.pred = 1'b1;
      e.nxt  = pc + 32'(off);
    end else if (i[6:0] == 7'h63 && bp) begin
      off = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      e.pred = 1'b1;
      e.nxt  = pc + 32'(off);
    end
    return e;
  endfunction

  task automatic step();
    bit     exp_valid;
    bit     do_push, do_pop;
    entry_t e;
    #1;
    exp_valid = rst_in && !clr_in && !m_halt && (mq.size() < DEPTH);
    chk("ic_valid", ic_valid, exp_valid);
    chk("ic_pc", ic_pc, m_pc);
    chk("bp_pc", bp_pc, m_pc);
    chk("out_valid", o_valid, mq.size() != 0);
    chk("count", count, mq.size());
    if (mq.size() != 0) begin
      chk("out_inst", o_inst, mq[0].inst);
      chk("out_pc", o_pc, mq[0].pc);
      chk("out_pred", o_pred, mq[0].pred);
      chk("out_pc_next", o_next, mq[0].nxt);
    end
    if (!rst_in) begin
      mq.delete(); m_pc = 32'h0; m_halt = 1'b0;
    end else if (rdy_in) begin
      if (clr_in) begin
        mq.delete(); m_pc = clr_pc; m_halt = 1'b0;
      end else begin
        do_push = exp_valid && ic_ready;
        do_pop  = (mq.size() != 0) && iu_ready;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          e = predict(ic_inst, m_pc, bp_pred);
          mq.push_back(e);
          m_pc = e.nxt;
          if (ic_inst[6:0] == 7'h67) m_halt = 1'b1;
        end
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 5);
    case (k)
      0:       return {r[31:7], 7'h6F};
      1, 2:    return {r[31:7], 7'h63};
      3:       return {r[31:7], 7'h67};
      4:       return ADDI;
      default: return (r[6:0] == 7'h67) ? ADDI : r;
    endcase
  endfunction

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0; clr_pc = 32'h0;
    ic_ready = 1'b0; ic_inst = ADDI; bp_pred = 1'b0; iu_ready = 1'b0;
    b_ic_ready = 1'b0; b_inst = ADDI;
    @(posedge clk_in);
    #1;

    repeat (3) step();
    chk("rst_out_valid", o_valid, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_ic_valid", ic_valid, 1'b0);

    rst_in = 1'b1; b_ic_ready = 1'b1; b_inst = JALR;
    #1;
    chk("rel_ic_pc", ic_pc, 32'h0);
    chk("rel_ic_valid", ic_valid, 1'b1);
    step();
    b_ic_ready = 1'b0;
    chk("nostall_pc", b_ic_pc, 32'h44);
    chk("nostall_valid", b_ic_valid, 1'b1);
    chk("nostall_out_pc", b_o_pc, 32'h40);

    ic_ready = 1'b1; ic_inst = ADDI;
    repeat (3) step();
    chk("seq_count", count, 3);
    chk("seq_out_pc", o_pc, 32'h0);
    chk("seq_pc_next", o_next, 32'h4);
    chk("seq_pred", o_pred, 1'b0);
    chk("seq_ic_pc", ic_pc, 32'hC);

    step();
    chk("full_count", count, 4);
    chk("full_ic_valid", ic_valid, 1'b0);
    iu_ready = 1'b1;
    step();
    chk("pop_count", count, 3);
    chk("pop_ic_valid", ic_valid, 1'b1);
    iu_ready = 1'b0;
    step();
    chk("refill_count", count, 4);

    clr_in = 1'b1; clr_pc = 32'h100; iu_ready = 1'b1;
    step();
    clr_in = 1'b0; iu_ready = 1'b0; ic_ready = 1'b0;
    #1;
    chk("flush_count", count, 0);
    chk("flush_out_valid", o_valid, 1'b0);
    chk("flush_pc", ic_pc, 32'h100);
    chk("flush_ic_valid", ic_valid, 1'b1);

    clr_in = 1'b1; clr_pc = 32'h10;
    step();
    clr_in = 1'b0; ic_ready = 1'b1; ic_inst = JAL20;
    step();
    chk("jal_pc", ic_pc, 32'h30);
    chk("jal_pred", o_pred, 1'b1);
    ic_inst = BRM8; bp_pred = 1'b1;
    step();
    chk("br_taken_pc", ic_pc, 32'h28);
    clr_in = 1'b1; clr_pc = 32'h30; ic_ready = 1'b0;
    step();
    clr_in = 1'b0; ic_ready = 1'b1; bp_pred = 1'b0;
    step();
    chk("br_nt_pc", ic_pc, 32'h34);
    chk("br_nt_next", o_next, 32'h34);

    clr_in = 1'b1; clr_pc = 32'h40;
    step();
    clr_in = 1'b0; ic_inst = JALR;
    step();
    chk("jalr_count", count, 1);
    chk("jalr_out_pc", o_pc, 32'h40);
    chk("jalr_halt_valid", ic_valid, 1'b0);
    ic_inst = ADDI;
    step();
    iu_ready = 1'b1;
    step();
    chk("jalr_drain", count, 0);
    chk("jalr_still_halt", ic_valid, 1'b0);
    clr_in = 1'b1; clr_pc = 32'h200;
    step();
    clr_in = 1'b0;
    #1;
    chk("resume_pc", ic_pc, 32'h200);
    chk("resume_valid", ic_valid, 1'b1);

    repeat (10) step();

    for (int n = 0; n < 3000; n++) begin
      rst_in   = ($urandom_range(0, 99) != 0);
      rdy_in   = ($urandom_range(0, 9) != 0);
      clr_in   = ($urandom_range(0, 19) == 0);
      clr_pc   = {$urandom_range(0, 32'hFFFF), 2'b00};
      ic_ready = ($urandom_range(0, 9) < 7);
      ic_inst  = rand_inst();
      bp_pred  = $urandom_range(0, 1) != 0;
      iu_ready = ($urandom_range(0, 9) < 4);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Decoupled front end for the out-of-order RISC-V core. It generates fetch PCs and requests instructions from the icache. It pre-decodes each returned word for JAL/branch prediction and buffers fetched instructions in a parametrised circular queue. The decode/issue stage pops them through a valid/ready handshake. It sits between the icache/branch predictor and the issue logic, and is flushed and redirected by the ROB on misprediction.

## Interface
- IFQ_WIDTH, default 4: log2 of queue depth; DEPTH = 2^IFQ_WIDTH entries.
- RESET_PC, default 32'h0: fetch PC after reset.
- JALR_STALL, default 1: 1 = halt fetch after a JALR until redirect; 0 = continue at pc+4.

- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  reset, synchronous, active-low.
- rdy_in  input  1  global enable; when 0 all state holds.
- clr_in  input  1  ROB flush/redirect.
- clr_pc_in  input  32  redirect target, valid with clr_in.
- ifq_to_ic_valid  output  1  fetch request valid.
- ifq_to_ic_pc  output  32  fetch address (current pc register).
- ic_to_ifq_ready  input  1  icache returns the word for the current ifq_to_ic_pc this cycle.
- ic_to_ifq_inst  input  32  instruction word.
- ifq_to_bp_pc  output  32  equals ifq_to_ic_pc.
- bp_to_ifq_prediction  input  1  combinational taken prediction for ifq_to_bp_pc.
- out_valid  output  1  queue head valid.
- out_inst  output  32  head instruction.
- out_pc  output  32  head PC.
- out_prediction  output  1  head predicted-taken bit.
- out_pc_next  output  32  head predicted next PC.
- iu_ready_in  input  1  consumer accepts head this cycle.
- ifq_count  output  IFQ_WIDTH+1  occupancy.

## Operation
- Storage: DEPTH entries of {inst, pc, prediction, pc_next}; head/tail pointers IFQ_WIDTH bits, wrap modulo DEPTH; count register IFQ_WIDTH+1 bits.
- FSM: RUN, HALT. Reset enters RUN.
- ifq_to_ic_valid = (state==RUN) && count!=DEPTH && rst_in && !clr_in.
- push = ifq_to_ic_valid && ic_to_ifq_ready && rdy_in. The icache contract: ready refers only to the current-cycle pc; if the pc changes, any in-flight miss is abandoned.
- Pre-decode on push, with opcode = inst[6:0] and pc = the current pc:
  - JAL (1101111): prediction=1, pc_next = pc + {{12{i[31]}},i[19:12],i[20],i[30:21],1'b0}.
  - Branch (1100011): prediction = bp_to_ifq_prediction; pc_next = taken ? pc + {{20{i[31]}},i[7],i[30:25],i[11:8],1'b0} : pc+4.
  - JALR (1100111): prediction=0, pc_next=pc+4; if JALR_STALL, state goes to HALT.
  - Other opcodes: prediction=0, pc_next=pc+4.
- On push the entry is written at tail; tail+1; the pc register is loaded with pc_next.
- pop = out_valid && iu_ready_in && rdy_in && !clr_in; on pop head+1. Push and pop in the same cycle leave count unchanged.
- out_valid = count!=0. out_* are read combinationally from entry[head].
- clr_in (with rdy_in) has priority over push/pop/HALT: head=tail=count=0, pc=clr_pc_in, state=RUN. The response in that cycle is discarded.
- HALT: no requests; pop continues; only clr_in exits.
- Arithmetic is 32-bit modulo; PC overflow wraps silently.

## Timing
- Reset (rst_in=0 at an edge): pc=RESET_PC, head=tail=count=0, state=RUN. Outputs: out_valid=0, ifq_count=0, ifq_to_ic_valid=0 while rst_in=0, ifq_to_ic_pc=RESET_PC. Entry contents are don't-care.
- Fetch-to-issue latency: ic_to_ifq_ready at cycle t gives out_valid=1 at t+1; the new pc is presented at t+1.
- Throughput is one instruction per cycle with a zero-wait icache, including taken JAL/branch (redirect costs no bubble).
- Full: when count==DEPTH, valid drops. A pop at cycle t gives count=DEPTH-1 at t+1, and the request resumes at t+1 (no same-cycle push-on-full).
- Empty: out_valid=0; iu_ready_in is ignored.
- clr_in at t: at t+1 out_valid=0, ifq_to_ic_pc=clr_pc_in, valid=1.
- rdy_in=0: nothing changes; ifq_to_ic_valid may still be high but no push occurs.

## Test plan
- Reset: hold rst_in=0 for 3 cycles with RESET_PC=0 -> out_valid=0, ifq_count=0, ifq_to_ic_valid=0. Release -> ifq_to_ic_pc=0, valid=1.
- Sequential: icache returns addi words at pc 0,4,8 on 3 consecutive cycles, iu_ready_in=0 -> ifq_count=3. Head out_pc=0, out_pc_next=4, out_prediction=0.
- JAL at pc 0x10 with offset +0x20 -> next request pc=0x30, entry prediction=1. Branch at 0x30 (offset -8): with BP=1 next pc=0x28; with BP=0 next pc=0x34.
- Backpressure with IFQ_WIDTH=2: push 4 -> ifq_count=4, ifq_to_ic_valid=0. Then one pop plus icache ready -> count 3 then 4. Verify pointer wrap over 10 push/pop cycles: FIFO order preserved.
- Flush: with 3 queued, assert clr_in with clr_pc_in=0x100 together with iu_ready_in and ic_to_ifq_ready -> next cycle count=0, out_valid=0, pc=0x100, and no stale entry ever appears.
- JALR with JALR_STALL=1 at 0x40 -> entry pushed, valid=0 thereafter; queue drains normally. clr_in with 0x200 -> fetch resumes at 0x200. With JALR_STALL=0 -> next pc=0x44.
